// File: rtl/intr_req_sched.sv
// rtl/intr_req_sched.sv - round-robin interrupt request scheduler with grant timeout
// Optional post-grant coalescing hold-off is compiled in with INTR_SCHED_COALESCE_EN.

module intr_req_sched #(
    parameter int NSRC    = 4,
    parameter int VECW    = 5,
    parameter int TMO     = 255,
    parameter int HOLDOFF = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NSRC-1:0]      i_src_req,
    input  logic [NSRC*VECW-1:0] i_src_vec,
    output logic                 o_msi_req,
    output logic [VECW-1:0]      o_msi_vec,
    input  logic                 i_msi_grant,
    output logic [NSRC-1:0]      o_pending,
    output logic                 o_busy,
    output logic [7:0]           o_tmo_cnt
);

    localparam int              PW       = $clog2(NSRC);
    localparam logic [PW-1:0]   RR_RST   = PW'(NSRC - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TMO - 1);

`ifdef INTR_SCHED_COALESCE_EN
    localparam logic [15:0]     HOLD_LAST = 16'(HOLDOFF - 1);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [NSRC-1:0]   src_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   clr;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     sel_q, sel_d;
    logic [VECW-1:0]   vec_q, vec_d;
    logic [15:0]       wait_q, wait_d;
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
    logic              arb_found;
    logic [PW-1:0]     arb_idx;
    logic [PW-1:0]     cand;

`ifdef INTR_SCHED_COALESCE_EN
    logic [15:0]       hold_q, hold_d;
`else
    logic              unused_holdoff;
    assign unused_holdoff = (HOLDOFF > 0);
`endif

    // First pending source strictly after rr_ptr, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NSRC; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NSRC);
            if (!arb_found && pending_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        vec_d     = vec_q;
        wait_d    = wait_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        clr       = '0;
`ifdef INTR_SCHED_COALESCE_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    sel_d   = arb_idx;
                    vec_d   = i_src_vec[arb_idx*VECW +: VECW];
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_msi_grant) begin
                    clr[sel_q] = 1'b1;
                    rr_ptr_d   = sel_q;
`ifdef INTR_SCHED_COALESCE_EN
                    hold_d     = '0;
                    state_d    = ST_HOLD;
`else
                    state_d    = ST_IDLE;
`endif
                end else if (wait_q == TMO_LAST) begin
                    rr_ptr_d = sel_q;
                    if (tmo_cnt_q != 8'hFF) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
`ifdef INTR_SCHED_COALESCE_EN
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // A new event in the grant cycle (raw or already sampled) keeps the flag set.
    assign pending_d = (pending_q & ~(clr & ~i_src_req)) | src_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pending_q <= '0;
            rr_ptr_q  <= RR_RST;
            sel_q     <= '0;
            vec_q     <= '0;
            wait_q    <= '0;
            tmo_cnt_q <= '0;
`ifdef INTR_SCHED_COALESCE_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= i_src_req;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            vec_q     <= vec_d;
            wait_q    <= wait_d;
            tmo_cnt_q <= tmo_cnt_d;
`ifdef INTR_SCHED_COALESCE_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign o_msi_req = (state_q == ST_REQ);
    assign o_msi_vec = o_msi_req ? vec_q : '0;
    assign o_pending = pending_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_tmo_cnt = tmo_cnt_q;

endmodule

// File: doc/intr_req_sched.md
INTR_REQ_SCHED -- requirements
Module: intr_req_sched

Interface
REQ-001 Parameter NSRC, default 4, number of interrupt requesters (2..16).
REQ-002 Parameter VECW, default 5, interrupt vector width.
REQ-003 Parameter TMO, default 255, grant-wait cycles before timeout (1..65535).
REQ-004 Parameter HOLDOFF, default 16, idle cycles after each grant (used only with coalescing compiled in).
REQ-005 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_src_req  input  NSRC  per-source event; sampled high on any cycle = one event.
REQ-008 i_src_vec  input  NSRC*VECW  per-source vector, slice i for source i; static while that source is pending.
REQ-009 o_msi_req  output  1  interrupt request toward the bridge interrupt port.
REQ-010 o_msi_vec  output  VECW  vector of the current request.
REQ-011 i_msi_grant  input  1  bridge acknowledge of the current request.
REQ-012 o_pending  output  NSRC  pending flags.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_tmo_cnt  output  8  saturating timeout-event counter.

Function
REQ-015 The block SHALL set pending[i] on the edge after i_src_req[i] is sampled high; repeated events while pending SHALL merge into one.
REQ-016 pending[i] SHALL clear on the edge where the request for source i is granted; if i_src_req[i] is high in that same cycle, set SHALL win.
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD; HOLD exists only with coalescing compiled in.
REQ-018 IDLE: if any pending, select the first pending index strictly after rr_ptr, wrapping modulo NSRC; latch index and its vector; go REQ.
REQ-019 REQ: o_msi_req=1, o_msi_vec=latched vector, both stable until leaving REQ.
REQ-020 Latency: source event sampled at edge N, pending at N+1, o_msi_req high after edge N+2 when IDLE with nothing else pending.
REQ-021 REQ with i_msi_grant=1: clear pending[sel], rr_ptr=sel, o_msi_req=0 next cycle, go IDLE (or HOLD if coalescing).
REQ-022 REQ wait counter SHALL start at 0 on entry; at TMO cycles without grant: deassert request, keep pending[sel], rr_ptr=sel, o_tmo_cnt+1 saturating at 255, go IDLE.
REQ-023 Grant and timeout in the same cycle SHALL be treated as grant (no counter increment).
REQ-024 i_msi_grant outside REQ SHALL be ignored.
REQ-025 Minimum gap between consecutive o_msi_req pulses SHALL be one low cycle (IDLE).
REQ-026 rr_ptr reset value SHALL be NSRC-1, so source 0 wins the first arbitration.

Reset
REQ-027 i_rst high at an edge SHALL force IDLE, pending=0, rr_ptr=NSRC-1, counters=0, o_msi_req=0, o_msi_vec=0, o_busy=0, o_tmo_cnt=0, discarding any in-flight request without counting it.
REQ-028 Source events sampled during reset SHALL be dropped.

Configuration
REQ-029 Macro INTR_SCHED_COALESCE_EN defined: after each grant, FSM enters HOLD for HOLDOFF cycles (o_busy=1, no request); events keep accumulating in pending; then IDLE.
REQ-030 Macro undefined: HOLD state and HOLDOFF counter absent; grant returns directly to IDLE; HOLDOFF ignored.

Verification
REQ-031 Single event: i_src_req=4'b0010, vec1=5'h03, grant 3 cycles after req -> o_msi_req rises 2 edges after event, o_msi_vec=5'h03, held 3 cycles, pending clears.
REQ-032 Round-robin: all four sources pending, immediate grants -> grant order 0,1,2,3; new event on 0 during grant of 2 -> order continues 3,0.
REQ-033 Timeout: TMO=4, source 2 pending, no grant -> req high exactly 4 cycles, o_tmo_cnt=1, pending[2] stays 1, source 3 (pending) served next.
REQ-034 Set/clear collision: i_src_req[1] high in grant cycle of source 1 -> pending[1] stays 1, second request for source 1 issued.
REQ-035 Reset mid-request: i_rst in REQ -> next cycle o_msi_req=0, pending=0, o_tmo_cnt=0; late grant ignored.
REQ-036 Coalescing (macro defined, HOLDOFF=16): two back-to-back events on different sources -> second o_msi_req rises 17 or more cycles after first grant.
